// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and frame-length helper.
// ST_PARITY is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam logic UART_IDLE = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_tx_state_t;

   // Clock cycles in one frame; shared with the receiver for timeout sizing.
   function automatic int unsigned uart_frame_cycles(
      input int unsigned data_bits,
      input int unsigned parity_bits,
      input int unsigned stop_bits,
      input int unsigned clk_div
   );
      return (1 + data_bits + parity_bits + stop_bits) * clk_div;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter for the UART: counts 0..CLK_DIV-1 while enabled, TICK marks the last cycle of a bit.
module uart_baud_gen #(
   parameter int CLK_DIV = 16
) (
   input  logic CLK,
   input  logic RESET,
   input  logic CLEAR,
   input  logic EN,
   output logic TICK
);

   localparam int CNT_W = $clog2(CLK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign TICK = (cnt_q == CNT_LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (CLEAR) begin
         cnt_d = '0;
      end else if (EN) begin
         cnt_d = TICK ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA LSB first, optional parity, STOP_BITS stop bits at CLK/CLK_DIV baud.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd when PARITY_ODD=1).
//
// state      | meaning
// ST_IDLE    | line high, READY asserted, baud counter held at 0
// ST_START   | line low for one bit time
// ST_DATA    | line = shift_q[0], shift right at each bit end
// ST_PARITY  | line = parity of the accepted word (UART_TX_PARITY_EN only)
// ST_STOP    | line high for STOP_BITS bit times
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int CLK_DIV    = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [DATA_BITS-1:0] DATA,
   input  logic                 VALID,
   output logic                 READY,
   output logic                 TX,
   output logic                 BUSY
);

   if (DATA_BITS < 5 || DATA_BITS > 9 || CLK_DIV < 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_param_check
      $error("uart_tx: illegal parameter combination");
   end

   localparam int BIT_W = $clog2(DATA_BITS);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic                 tx_q, tx_d;
   logic                 accept;
   logic                 tick;
   logic                 baud_clear;
   logic                 baud_en;

`ifdef UART_TX_PARITY_EN
   logic parity_q, parity_d;
`endif

   assign READY      = (state_q == ST_IDLE) && !RESET;
   assign BUSY       = (state_q != ST_IDLE);
   assign TX         = tx_q;
   assign accept     = VALID && READY;
   assign baud_clear = (state_q == ST_IDLE);
   assign baud_en    = BUSY;

   uart_baud_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_gen (
      .CLK   (CLK),
      .RESET (RESET),
      .CLEAR (baud_clear),
      .EN    (baud_en),
      .TICK  (tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_idx_d = stop_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               shift_d    = DATA;
               bit_idx_d  = '0;
               stop_idx_d = 1'b0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               if (bit_idx_q == BIT_LAST) begin
                  bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + BIT_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (stop_idx_q == STOP_LAST) begin
                  state_d = ST_IDLE;
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef UART_TX_PARITY_EN
   // Parity is taken from the word at acceptance since the shift register is consumed by then.
   always_comb begin
      parity_d = parity_q;
      if (accept) begin
         parity_d = (^DATA) ^ 1'(PARITY_ODD);
      end
   end
`endif

   // The line is registered from next state so the first start-bit cycle follows the acceptance edge.
   always_comb begin
      tx_d = UART_IDLE;
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: tx_d = parity_q;
`endif
         default:   tx_d = UART_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         tx_q       <= UART_IDLE;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         tx_q       <= tx_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: two instances (8N1 /16 and 7-bit, 2 stop, /4, odd parity when enabled)
// compared cycle by cycle against a bit-list frame model built from the word.
module tb_uart_tx;

   localparam int A_DB = 8;
   localparam int A_CD = 16;
   localparam int A_SB = 1;
   localparam int A_PO = 0;
   localparam int B_DB = 7;
   localparam int B_CD = 4;
   localparam int B_SB = 2;
   localparam int B_PO = 1;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] data_a;
   logic       valid_a, ready_a, tx_a, busy_a;
   logic [6:0] data_b;
   logic       valid_b, ready_b, tx_b, busy_b;

   int checks = 0;
   int errors = 0;

   int p_db[2] = '{A_DB, B_DB};
   int p_cd[2] = '{A_CD, B_CD};
   int p_sb[2] = '{A_SB, B_SB};
   int p_po[2] = '{A_PO, B_PO};

   always #5 clk = ~clk;

   uart_tx #(
      .DATA_BITS  (A_DB),
      .CLK_DIV    (A_CD),
      .STOP_BITS  (A_SB),
      .PARITY_ODD (A_PO)
   ) u_dut_a (
      .CLK   (clk),
      .RESET (rst),
      .DATA  (data_a),
      .VALID (valid_a),
      .READY (ready_a),
      .TX    (tx_a),
      .BUSY  (busy_a)
   );

   uart_tx #(
      .DATA_BITS  (B_DB),
      .CLK_DIV    (B_CD),
      .STOP_BITS  (B_SB),
      .PARITY_ODD (B_PO)
   ) u_dut_b (
      .CLK   (clk),
      .RESET (rst),
      .DATA  (data_b),
      .VALID (valid_b),
      .READY (ready_b),
      .TX    (tx_b),
      .BUSY  (busy_b)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic dut_tx(input int inst);
      return (inst == 0) ? tx_a : tx_b;
   endfunction

   function automatic logic dut_ready(input int inst);
      return (inst == 0) ? ready_a : ready_b;
   endfunction

   function automatic logic dut_busy(input int inst);
      return (inst == 0) ? busy_a : busy_b;
   endfunction

   task automatic drive(input int inst, input logic v, input logic [8:0] w);
      if (inst == 0) begin
         valid_a = v;
         data_a  = w[7:0];
      end else begin
         valid_b = v;
         data_b  = w[6:0];
      end
   endtask

   task automatic wait_ready(input int inst, output bit ok);
      int n = 0;
      while (!dut_ready(inst) && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = dut_ready(inst);
      if (!ok) check_val($sformatf("ready_timeout%0d", inst), 32'd0, 32'd1);
   endtask

   // Line model: list of bit levels for the frame, each held CLK_DIV cycles.
   task automatic send(input int inst, input logic [8:0] w, input bit hold, input bit scramble);
      bit exp_q[$];
      int ones = 0;
      int len;
      bit ok;
      exp_q.push_back(1'b0);
      for (int i = 0; i < p_db[inst]; i++) begin
         exp_q.push_back(w[i]);
         ones += int'(w[i]);
      end
      if (PAR_BITS == 1) exp_q.push_back(bit'((ones + p_po[inst]) % 2));
      for (int i = 0; i < p_sb[inst]; i++) exp_q.push_back(1'b1);
      len = exp_q.size() * p_cd[inst];

      drive(inst, 1'b1, w);
      wait_ready(inst, ok);
      if (!ok) begin
         drive(inst, 1'b0, w);
         return;
      end
      @(posedge clk);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         check_val($sformatf("tx%0d_w%0h_c%0d", inst, w, k + 1), 32'(dut_tx(inst)),
                   32'(exp_q[k / p_cd[inst]]));
         check_val($sformatf("busy%0d", inst), 32'(dut_busy(inst)), 32'd1);
         check_val($sformatf("ready_low%0d", inst), 32'(dut_ready(inst)), 32'd0);
         if (scramble) drive(inst, 1'($urandom), 9'($urandom));
         else if (!hold) drive(inst, 1'b0, w);
      end
      @(negedge clk);
      check_val($sformatf("ready_after%0d", inst), 32'(dut_ready(inst)), 32'd1);
      check_val($sformatf("tx_idle%0d", inst), 32'(dut_tx(inst)), 32'd1);
      check_val($sformatf("busy_after%0d", inst), 32'(dut_busy(inst)), 32'd0);
      if (!hold) drive(inst, 1'b0, w);
   endtask

   task automatic reset_mid_frame(input logic [8:0] w);
      bit ok;
      drive(0, 1'b1, w);
      wait_ready(0, ok);
      if (!ok) return;
      @(posedge clk);
      // Data bit 3 spans cycles 65..80 after acceptance at CLK_DIV=16.
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         drive(0, 1'b0, w);
      end
      check_val("tx_bit3", 32'(tx_a), 32'(w[3]));
      check_val("busy_bit3", 32'(busy_a), 32'd1);
      rst = 1'b1;
      drive(0, 1'b1, 9'h1FF);
      @(negedge clk);
      check_val("tx_rst", 32'(tx_a), 32'd1);
      check_val("busy_rst", 32'(busy_a), 32'd0);
      check_val("ready_rst", 32'(ready_a), 32'd0);
      rst = 1'b0;
      drive(0, 1'b0, w);
      @(negedge clk);
      check_val("ready_post_rst", 32'(ready_a), 32'd1);
      check_val("busy_no_collision", 32'(busy_a), 32'd0);
      check_val("tx_post_rst", 32'(tx_a), 32'd1);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 1'b0, 9'h0);
      drive(1, 1'b0, 9'h0);
      repeat (3) @(negedge clk);
      check_val("rst_tx_a", 32'(tx_a), 32'd1);
      check_val("rst_busy_a", 32'(busy_a), 32'd0);
      check_val("rst_ready_a", 32'(ready_a), 32'd0);
      check_val("rst_tx_b", 32'(tx_b), 32'd1);
      check_val("rst_busy_b", 32'(busy_b), 32'd0);
      check_val("rst_ready_b", 32'(ready_b), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check_val("ready_a_first", 32'(ready_a), 32'd1);
      check_val("ready_b_first", 32'(ready_b), 32'd1);

      send(0, 9'h041, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      send(0, 9'h002, 1'b1, 1'b0);
      send(0, 9'h003, 1'b1, 1'b0);
      send(0, 9'h004, 1'b1, 1'b0);
      send(0, 9'h005, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      send(0, 9'h0A5, 1'b0, 1'b1);
      drive(0, 1'b0, 9'h0);
      repeat (3) @(negedge clk);
      reset_mid_frame(9'h0C9);
      send(0, 9'h055, 1'b0, 1'b0);

      send(1, 9'h007, 1'b0, 1'b0);
      send(1, 9'h07F, 1'b1, 1'b0);
      send(1, 9'h000, 1'b0, 1'b1);
      drive(1, 1'b0, 9'h0);

      for (int i = 0; i < 12; i++) begin
         bit hold = 1'($urandom);
         send(0, 9'($urandom), hold, 1'($urandom));
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drive(0, 1'b0, 9'h0);

      for (int i = 0; i < 24; i++) begin
         bit hold = 1'($urandom);
         send(1, 9'($urandom), hold, 1'($urandom));
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      drive(1, 1'b0, 9'h0);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

endmodule
